// File: rtl/dpc_clock_reset_gen.sv
// Tick and reset source for the DekatronPC core: derives 1 ms / 1 s strobes from hsClk
// and releases the core's active-low reset a fixed number of ms ticks after Rst drops.
module dpc_clock_reset_gen #(
  parameter int unsigned DIV_1MS        = 10000,
  parameter int unsigned RST_HOLD_TICKS = 5,
  parameter int unsigned MS_PER_S       = 1000
) (
  input  logic hsClk,
  input  logic Rst,
  input  logic Hold,
  output logic Rst_n,
  output logic Clk1ms,
  output logic Clk1s,
  output logic Ready
);

  localparam int unsigned DIV_W  = $clog2(DIV_1MS);
  // MS_PER_S=1 would yield a zero-width counter; keep one bit that never leaves 0
  localparam int unsigned MS_W   = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HOLD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [MS_W-1:0]     r_ms;
  logic [MS_W-1:0]     w_ms_nxt;
  logic [HOLD_W-1:0]   r_hcnt;
  logic [HOLD_W-1:0]   w_hcnt_nxt;
  logic                r_rst_n;
  logic                r_ready;
  logic                r_clk1ms;
  logic                r_clk1s;
  logic                w_tick;
  logic                w_ms_wrap;
  logic                w_rst_n_nxt;

  // State and counter registers; Rst clears everything on the next edge
  always_ff @(posedge hsClk) begin
    if (Rst) begin
      r_state  <= S_RESET;
      r_div    <= '0;
      r_ms     <= '0;
      r_hcnt   <= '0;
      r_rst_n  <= 1'b0;
      r_ready  <= 1'b0;
      r_clk1ms <= 1'b0;
      r_clk1s  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_ms     <= w_ms_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_rst_n  <= w_rst_n_nxt;
      r_ready  <= w_rst_n_nxt;
      r_clk1ms <= w_tick;
      r_clk1s  <= w_ms_wrap;
    end
  end

  // Divider, ms counter, hold counter and release sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_ms_nxt    = r_ms;
    w_hcnt_nxt  = r_hcnt;
    w_tick      = 1'b0;
    w_ms_wrap   = 1'b0;

    if (!Hold) begin
      w_tick = (r_div == DIV_W'(DIV_1MS - 1));
      w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
    end

    if (w_tick) begin
      w_ms_wrap = (r_ms == MS_W'(MS_PER_S - 1));
      w_ms_nxt  = w_ms_wrap ? '0 : r_ms + MS_W'(1);
      if (r_hcnt != HOLD_W'(RST_HOLD_TICKS)) begin
        w_hcnt_nxt = r_hcnt + HOLD_W'(1);
      end
    end

    case (r_state)
      S_RESET: w_state_nxt = S_HOLD;
      // Release one cycle after the final hold tick so no core edge coincides with a tick
      S_HOLD: begin
        if (!Hold && (r_hcnt == HOLD_W'(RST_HOLD_TICKS))) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_RESET;
    endcase

    w_rst_n_nxt = (w_state_nxt == S_RUN);
  end

  assign Rst_n  = r_rst_n;
  assign Ready  = r_ready;
  assign Clk1ms = r_clk1ms;
  assign Clk1s  = r_clk1s;

endmodule

// File: tb/tb_dpc_clock_reset_gen.sv
// Scoreboard bench for dpc_clock_reset_gen: directed sequences with hand-derived tick/reset
// masks (DIV=4, HOLD=2, MS=3) plus a long-run count check on a MS_PER_S=1000 instance.
module tb_dpc_clock_reset_gen;

  logic clk;
  logic rst;
  logic hold;
  logic rst_n, clk1ms, clk1s, ready;
  logic rst_n2, clk1ms2, clk1s2, ready2;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] sb_q[$];

  dpc_clock_reset_gen #(.DIV_1MS(4), .RST_HOLD_TICKS(2), .MS_PER_S(3)) u_dut (
    .hsClk (clk),
    .Rst   (rst),
    .Hold  (hold),
    .Rst_n (rst_n),
    .Clk1ms(clk1ms),
    .Clk1s (clk1s),
    .Ready (ready)
  );

  dpc_clock_reset_gen #(.DIV_1MS(4), .RST_HOLD_TICKS(2), .MS_PER_S(1000)) u_dut_s (
    .hsClk (clk),
    .Rst   (rst),
    .Hold  (hold),
    .Rst_n (rst_n2),
    .Clk1ms(clk1ms2),
    .Clk1s (clk1s2),
    .Ready (ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // Monitor: one expected vector {Rst_n, Ready, Clk1ms, Clk1s} per observed cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      logic [3:0] e;
      logic [3:0] a;
      e = sb_q.pop_front();
      a = {rst_n, ready, clk1ms, clk1s};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL vec%0d {Rst_n,Ready,Clk1ms,Clk1s} got=%b exp=%b at t=%0t", n_vec, a, e, $time);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] every(input int first, input int step, input int last);
    logic [63:0] m;
    m = '0;
    for (int i = first; i <= last; i += step) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic apply_reset();
    for (int i = 0; i < 5; i++) begin
      rst  = 1'b1;
      hold = 1'b0;
      @(posedge clk);
      sb_q.push_back(4'b0000);
      #1;
    end
  endtask

  // Cycle c input is sampled at the edge ending cycle c; the expectation is for cycle c+1
  task automatic run_seq(input int n, input int rst_cyc, input int hlo, input int hhi,
                         input logic [63:0] tk, input logic [63:0] sm, input logic [63:0] rn);
    for (int c = 0; c < n; c++) begin
      rst  = (c == rst_cyc);
      hold = (c >= hlo) && (c <= hhi);
      @(posedge clk);
      sb_q.push_back({rn[c+1], rn[c+1], tk[c+1], sm[c+1]});
      #1;
    end
  endtask

  initial begin
    int n_ms, n_s, n_consec, n_alone, first_s;
    logic prev_ms;
    rst  = 1'b1;
    hold = 1'b0;
    @(posedge clk);
    #1;

    // 1: plain release
    apply_reset();
    run_seq(26, -1, 0, -1, every(4, 4, 26), every(12, 12, 26), span(9, 26));

    // 2: one-cycle Rst in cycle 10, sequence restarts
    apply_reset();
    run_seq(26, 10, 0, -1, every(4, 4, 8) | every(15, 4, 26), every(23, 12, 23),
            span(9, 10) | span(20, 26));

    // 3: Hold during cycles 2-4 delays everything by three cycles
    apply_reset();
    run_seq(20, -1, 2, 4, every(7, 4, 20), every(15, 12, 20), span(12, 20));

    // 4: long Hold in RUN freezes ticks, Rst_n stays high
    apply_reset();
    run_seq(40, -1, 10, 29, every(4, 4, 8) | every(32, 4, 40), every(32, 12, 40), span(9, 40));

    // 5: Rst in the tick cycle just before release
    apply_reset();
    run_seq(18, 8, 0, -1, every(4, 4, 8) | every(13, 4, 18), '0, span(18, 18));

    // 6: long run on the MS_PER_S=1000 instance
    apply_reset();
    rst  = 1'b0;
    hold = 1'b0;
    n_ms = 0; n_s = 0; n_consec = 0; n_alone = 0; first_s = 0;
    prev_ms = 1'b0;
    for (int c = 1; c <= 10000; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (clk1ms2) n_ms++;
      if (clk1s2) begin
        n_s++;
        if (first_s == 0) first_s = c;
      end
      if (clk1ms2 && prev_ms) n_consec++;
      if (clk1s2 && !clk1ms2) n_alone++;
      prev_ms = clk1ms2;
    end
    chk("long_clk1ms_count", n_ms, 2500);
    chk("long_clk1s_count", n_s, 2);
    chk("long_first_clk1s_cycle", first_s, 4000);
    chk("long_consecutive_clk1ms", n_consec, 0);
    chk("long_clk1s_without_clk1ms", n_alone, 0);
    chk("long_rst_n_released", int'(rst_n2), 1);
    chk("long_ready_released", int'(ready2), 1);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
